// File: rtl/fp_pkg.sv
// Shared floating-point types for the divide/sqrt datapath.
//   fp_format_e / fp_width() : storage format and its bit width
//   roundmode_e              : IEEE rounding modes handed to fp_rnd
//   uround_res_t             : unrounded result produced by fp_div / fp_sqrt
//   divsqrt_op_e             : operation selector for the issue stage
//   divsqrt_state_e          : issue-stage sequencing states
package fp_pkg;

  typedef enum logic [1:0] {
    FP16 = 2'd0,
    FP32 = 2'd1,
    FP64 = 2'd2
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } roundmode_e;

  // Mantissa carries the hidden bit plus guard/round; sticky is kept apart so
  // fp_rnd can fold it without re-deriving it from the shifted-out bits.
  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] mant;
    logic        sticky;
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
  } uround_res_t;

  typedef enum logic {
    OP_DIV  = 1'b0,
    OP_SQRT = 1'b1
  } divsqrt_op_e;

  typedef enum logic [2:0] {
    DS_IDLE  = 3'd0,
    DS_START = 3'd1,
    DS_BLANK = 3'd2,
    DS_BUSY  = 3'd3,
    DS_HOLD  = 3'd4
  } divsqrt_state_e;

  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP16:    return 16;
      FP64:    return 64;
      default: return 32;
    endcase
  endfunction

endpackage

// File: rtl/fp_divsqrt_issue.sv
// Issue/sequencing stage in front of the iterative fp_div / fp_sqrt units.
// Accepts one request at a time, latches operands, rounding mode and tag,
// pulses the selected unit's start, waits for its done, captures the
// unrounded result (plus divide-by-zero for DIV) and offers it to fp_rnd.
//   clk_i, reset_i (async, active low), kill_i (sync abort)
//   req_*      : request handshake and payload
//   div_*      : start/operands out, done/result/dz in for fp_div
//   sqrt_*     : start/operand out, done/result in for fp_sqrt
//   unit_rnd_o : latched rounding mode to both units
//   rsp_*      : response handshake and payload towards fp_rnd
//   ops_cnt_o  : completed-operation counter (wraps)
module fp_divsqrt_issue
  import fp_pkg::*;
#(
  parameter fp_format_e  FP_FORMAT = FP32,
  parameter int unsigned TAG_WIDTH = 4,
  localparam int unsigned FP_WIDTH = fp_width(FP_FORMAT)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 kill_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  divsqrt_op_e          req_op_i,
  input  logic [FP_WIDTH-1:0]  req_a_i,
  input  logic [FP_WIDTH-1:0]  req_b_i,
  input  roundmode_e           req_rnd_i,
  input  logic [TAG_WIDTH-1:0] req_tag_i,
  output logic                 div_start_o,
  output logic [FP_WIDTH-1:0]  div_a_o,
  output logic [FP_WIDTH-1:0]  div_b_o,
  input  logic                 div_done_i,
  input  uround_res_t          div_urnd_i,
  input  logic                 div_dz_i,
  output logic                 sqrt_start_o,
  output logic [FP_WIDTH-1:0]  sqrt_a_o,
  input  logic                 sqrt_done_i,
  input  uround_res_t          sqrt_urnd_i,
  output roundmode_e           unit_rnd_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output uround_res_t          rsp_urnd_o,
  output roundmode_e           rsp_rnd_o,
  output logic                 rsp_dz_o,
  output logic [TAG_WIDTH-1:0] rsp_tag_o,
  output logic [31:0]          ops_cnt_o
);

  divsqrt_state_e       state_q;
  divsqrt_op_e          op_q;
  logic [FP_WIDTH-1:0]  a_q, b_q;
  roundmode_e           rnd_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 sel_done;
  logic                 req_fire;

  // Ready is low throughout reset. In HOLD a new request may be taken only in
  // the cycle the response leaves, which gives back-to-back issue.
  assign req_ready_o = reset_i & ((state_q == DS_IDLE) |
                                  ((state_q == DS_HOLD) & rsp_ready_i));
  assign req_fire    = req_valid_i & req_ready_o;

  // Only the unit that owns the operation may complete it.
  assign sel_done = (op_q == OP_SQRT) ? sqrt_done_i : div_done_i;

  // Operand/mode latches only load on acceptance, so they are stable from
  // START until the FSM leaves HOLD.
  assign div_a_o    = a_q;
  assign div_b_o    = b_q;
  assign sqrt_a_o   = a_q;
  assign unit_rnd_o = rnd_q;
  assign rsp_rnd_o  = rnd_q;
  assign rsp_tag_o  = tag_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= DS_IDLE;
      op_q         <= OP_DIV;
      a_q          <= '0;
      b_q          <= '0;
      rnd_q        <= RNE;
      tag_q        <= '0;
      div_start_o  <= 1'b0;
      sqrt_start_o <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_urnd_o   <= '0;
      rsp_dz_o     <= 1'b0;
      ops_cnt_o    <= '0;
    end else begin
      // Start lines are one-cycle pulses; they only rise on acceptance.
      div_start_o  <= 1'b0;
      sqrt_start_o <= 1'b0;
      if (kill_i) begin
        // A pulse already on the start line this cycle still goes out; the
        // unit's later done is dropped because we are no longer in BUSY.
        state_q     <= DS_IDLE;
        rsp_valid_o <= 1'b0;
      end else begin
        unique case (state_q)
          DS_IDLE:  ;
          DS_START: state_q <= DS_BLANK;
          // BLANK masks a done level still high from the previous operation.
          DS_BLANK: state_q <= DS_BUSY;
          DS_BUSY: begin
            if (sel_done) begin
              rsp_urnd_o  <= (op_q == OP_SQRT) ? sqrt_urnd_i : div_urnd_i;
              rsp_dz_o    <= (op_q == OP_DIV) & div_dz_i;
              rsp_valid_o <= 1'b1;
              state_q     <= DS_HOLD;
            end
          end
          DS_HOLD: begin
            if (rsp_ready_i) begin
              rsp_valid_o <= 1'b0;
              ops_cnt_o   <= ops_cnt_o + 32'd1;
              state_q     <= DS_IDLE;
            end
          end
          default: state_q <= DS_IDLE;
        endcase
        // Acceptance overrides the IDLE return above for back-to-back issue.
        if (req_fire) begin
          state_q      <= DS_START;
          op_q         <= req_op_i;
          a_q          <= req_a_i;
          b_q          <= req_b_i;
          rnd_q        <= req_rnd_i;
          tag_q        <= req_tag_i;
          div_start_o  <= (req_op_i == OP_DIV);
          sqrt_start_o <= (req_op_i == OP_SQRT);
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_divsqrt_issue.sv
// Bench for fp_divsqrt_issue: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a transaction
// model that tracks "cycles since acceptance" for the one in-flight request.
module tb_fp_divsqrt_issue;
  import fp_pkg::*;

  localparam int URW = $bits(uround_res_t);
  localparam uround_res_t URND_2   = '{sign: 1'b0, exp: 10'd1, mant: 27'h4000000,
                                       sticky: 1'b0, is_nan: 1'b0, is_inf: 1'b0, is_zero: 1'b0};
  localparam uround_res_t URND_INF = '{sign: 1'b0, exp: 10'h3ff, mant: 27'h0,
                                       sticky: 1'b0, is_nan: 1'b0, is_inf: 1'b1, is_zero: 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i = 1'b1, kill_i = 1'b0, req_valid_i = 1'b0, rsp_ready_i = 1'b0;
  divsqrt_op_e req_op_i = OP_DIV;
  logic [31:0] req_a_i = '0, req_b_i = '0;
  roundmode_e  req_rnd_i = RNE;
  logic [3:0]  req_tag_i = '0;
  logic        div_done_i = 1'b0, div_dz_i = 1'b0, sqrt_done_i = 1'b0;
  uround_res_t div_urnd_i = '0, sqrt_urnd_i = '0;

  logic        req_ready_o, div_start_o, sqrt_start_o, rsp_valid_o, rsp_dz_o;
  logic [31:0] div_a_o, div_b_o, sqrt_a_o, ops_cnt_o;
  roundmode_e  unit_rnd_o, rsp_rnd_o;
  uround_res_t rsp_urnd_o;
  logic [3:0]  rsp_tag_o;

  fp_divsqrt_issue #(.FP_FORMAT(FP32), .TAG_WIDTH(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .kill_i(kill_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rnd_i(req_rnd_i), .req_tag_i(req_tag_i),
    .div_start_o(div_start_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
    .div_done_i(div_done_i), .div_urnd_i(div_urnd_i), .div_dz_i(div_dz_i),
    .sqrt_start_o(sqrt_start_o), .sqrt_a_o(sqrt_a_o), .sqrt_done_i(sqrt_done_i),
    .sqrt_urnd_i(sqrt_urnd_i), .unit_rnd_o(unit_rnd_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_urnd_o(rsp_urnd_o),
    .rsp_rnd_o(rsp_rnd_o), .rsp_dz_o(rsp_dz_o), .rsp_tag_o(rsp_tag_o), .ops_cnt_o(ops_cnt_o)
  );

  int n_chk = 0, n_err = 0;

  // ---- reference model: one request in flight, aged in cycles ----
  bit          m_busy = 0, m_hold = 0;
  int          m_age = 0;
  divsqrt_op_e m_op = OP_DIV;
  logic [31:0] m_a = '0, m_b = '0;
  roundmode_e  m_rnd = RNE;
  logic [3:0]  m_tag = '0;
  uround_res_t m_urnd = '0;
  logic        m_dz = 1'b0;
  logic [31:0] m_cnt = '0;

  // unit behaviour for the current request, and its pending values
  int          u_lat = 1, nx_lat = 1;
  uround_res_t u_res = '0, nx_res = '0;
  logic        u_dz = 1'b0, nx_dz = 1'b0;
  bit          auto_en = 1, noise_en = 0, x_div_done = 0, x_sqrt_done = 0;

  // values observed in the last tick
  logic        s_req_ready, s_div_start, s_sqrt_start, s_rsp_valid, s_rsp_dz;
  logic [3:0]  s_rsp_tag;
  uround_res_t s_rsp_urnd;
  logic [31:0] s_ops_cnt;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return reset_i && (!m_busy || (m_hold && rsp_ready_i));
  endfunction

  task automatic m_reset();
    m_busy = 0; m_hold = 0; m_age = 0; m_cnt = '0; m_urnd = '0; m_dz = 1'b0;
  endtask

  task automatic set_req(input divsqrt_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input roundmode_e rnd, input logic [3:0] tag, input int lat,
                         input uround_res_t res, input logic dz);
    req_op_i = op; req_a_i = a; req_b_i = b; req_rnd_i = rnd; req_tag_i = tag;
    nx_lat = lat; nx_res = res; nx_dz = dz;
  endtask

  task automatic rand_req();
    logic [63:0] r;
    r = {$urandom, $urandom};
    set_req(divsqrt_op_e'(1'($urandom_range(0, 1))), $urandom, $urandom,
            roundmode_e'(3'($urandom_range(0, 4))), 4'($urandom_range(0, 15)),
            $urandom_range(1, 12), r[URW-1:0], 1'($urandom_range(0, 1)));
  endtask

  task automatic drive_units();
    bit dd, sd, ad;
    logic [63:0] j1, j2;
    j1 = {$urandom, $urandom};
    j2 = {$urandom, $urandom};
    ad = auto_en && m_busy && !m_hold && (m_age == 2 + u_lat);
    dd = ad && (m_op == OP_DIV);
    sd = ad && (m_op == OP_SQRT);
    div_done_i  = dd | x_div_done  | (noise_en && $urandom_range(0, 99) < 3);
    sqrt_done_i = sd | x_sqrt_done | (noise_en && $urandom_range(0, 99) < 3);
    div_urnd_i  = dd ? u_res : j1[URW-1:0];
    sqrt_urnd_i = sd ? u_res : j2[URW-1:0];
    div_dz_i    = dd ? u_dz : 1'($urandom_range(0, 1));
  endtask

  task automatic check();
    chk("req_ready", req_ready_o, exp_ready());
    chk("div_start", div_start_o, m_busy && !m_hold && m_age == 1 && m_op == OP_DIV);
    chk("sqrt_start", sqrt_start_o, m_busy && !m_hold && m_age == 1 && m_op == OP_SQRT);
    chk("rsp_valid", rsp_valid_o, m_hold);
    chk("ops_cnt", ops_cnt_o, m_cnt);
    if (m_busy) begin
      chk("div_a", div_a_o, m_a);
      chk("div_b", div_b_o, m_b);
      chk("sqrt_a", sqrt_a_o, m_a);
      chk("unit_rnd", unit_rnd_o, m_rnd);
    end
    if (m_hold) begin
      chk("rsp_urnd", rsp_urnd_o, m_urnd);
      chk("rsp_dz", rsp_dz_o, m_dz);
      chk("rsp_tag", rsp_tag_o, m_tag);
      chk("rsp_rnd", rsp_rnd_o, m_rnd);
    end
  endtask

  // What the clock edge must do with the inputs of this cycle.
  task automatic model_step();
    bit rdy;
    rdy = exp_ready();
    if (!reset_i) begin m_reset(); return; end
    if (kill_i) begin m_busy = 0; m_hold = 0; return; end
    if (m_hold && rsp_ready_i) begin
      m_cnt = m_cnt + 32'd1; m_hold = 0; m_busy = 0;
    end else if (m_busy && !m_hold) begin
      if (m_age >= 3 && ((m_op == OP_SQRT) ? sqrt_done_i : div_done_i)) begin
        m_hold = 1;
        m_urnd = (m_op == OP_SQRT) ? sqrt_urnd_i : div_urnd_i;
        m_dz   = (m_op == OP_DIV) ? div_dz_i : 1'b0;
      end
      m_age++;
    end
    if (req_valid_i && rdy) begin
      m_busy = 1; m_hold = 0; m_age = 1;
      m_op = req_op_i; m_a = req_a_i; m_b = req_b_i; m_rnd = req_rnd_i; m_tag = req_tag_i;
      u_lat = nx_lat; u_res = nx_res; u_dz = nx_dz;
    end
  endtask

  // Called at a falling edge with this cycle's inputs already driven.
  task automatic tick();
    drive_units();
    #1;
    s_req_ready = req_ready_o; s_div_start = div_start_o; s_sqrt_start = sqrt_start_o;
    s_rsp_valid = rsp_valid_o; s_rsp_dz = rsp_dz_o; s_rsp_tag = rsp_tag_o;
    s_rsp_urnd = rsp_urnd_o; s_ops_cnt = ops_cnt_o;
    check();
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_i = 1'b0; m_reset();
    tick(); tick();
    reset_i = 1'b1;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int h1, st2, nreq;
    logic [63:0] r;

    // reset
    #1 reset_i = 1'b0; m_reset();
    @(negedge clk);
    tick();
    chk("rst_ready_low", s_req_ready, 1'b0);
    chk("rst_cnt", s_ops_cnt, 32'd0);
    chk("rst_unit_rnd", unit_rnd_o, RNE);
    reset_i = 1'b1;
    tick();
    chk("rst_ready_after", s_req_ready, 1'b1);

    // SQRT 4.0 -> 2.0, done 26 cycles after BLANK
    rsp_ready_i = 1'b1;
    set_req(OP_SQRT, 32'h40800000, 32'h12345678, RNE, 4'd3, 26, URND_2, 1'b0);
    req_valid_i = 1'b1;
    tick();
    chk("sqrt_accept", s_req_ready, 1'b1);
    req_valid_i = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk("sqrt_no_div_start", s_div_start, 1'b0);
      chk("sqrt_start_cycle", s_sqrt_start, k == 1);
      chk("sqrt_rsp_cycle", s_rsp_valid, k == 29);
      if (k == 29) begin
        chk("sqrt_tag", s_rsp_tag, 4'd3);
        chk("sqrt_dz", s_rsp_dz, 1'b0);
        chk("sqrt_urnd", s_rsp_urnd, URND_2);
      end
    end

    // DIV by zero, response held 5 cycles
    rsp_ready_i = 1'b0;
    set_req(OP_DIV, 32'h3F800000, 32'h00000000, RTZ, 4'd5, 5, URND_INF, 1'b1);
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      rsp_ready_i = (k == 13);
      tick();
      chk("dz_rsp_window", s_rsp_valid, k >= 8 && k <= 13);
      if (k >= 8 && k <= 13) begin
        chk("dz_flag", s_rsp_dz, 1'b1);
        chk("dz_urnd_held", s_rsp_urnd, URND_INF);
      end
    end
    chk("dz_cnt", s_ops_cnt, 32'd2);

    // back-to-back
    do_reset();
    rsp_ready_i = 1'b1;
    set_req(OP_DIV, 32'h40000000, 32'h3F000000, RNE, 4'd1, 4, URND_2, 1'b0);
    req_valid_i = 1'b1;
    nreq = 0; h1 = -1; st2 = -1;
    for (int k = 0; k <= 20; k++) begin
      tick();
      if (s_rsp_valid && h1 < 0) h1 = k;
      if (s_sqrt_start && st2 < 0) st2 = k;
      if (s_req_ready && req_valid_i) begin
        nreq++;
        if (nreq == 1) set_req(OP_SQRT, 32'h41100000, 32'h0, RMM, 4'd2, 3, URND_INF, 1'b0);
        else req_valid_i = 1'b0;
      end
    end
    chk("b2b_first_rsp", h1, 7);
    chk("b2b_gap", st2 - h1, 1);
    chk("b2b_cnt", s_ops_cnt, 32'd2);

    // stale sqrt done into BLANK, cross-unit div done during SQRT
    r = {$urandom, $urandom};
    set_req(OP_SQRT, 32'h40100000, 32'h0, RDN, 4'd7, 6, r[URW-1:0], 1'b0);
    for (int k = 0; k <= 11; k++) begin
      x_sqrt_done = (k <= 2);
      x_div_done  = (k >= 3 && k <= 7);
      req_valid_i = (k == 0);
      tick();
      chk("stale_rsp_cycle", s_rsp_valid, k == 9);
    end
    x_sqrt_done = 0; x_div_done = 0; req_valid_i = 1'b0;

    // kill in BUSY, late done ignored
    set_req(OP_DIV, 32'h40400000, 32'h40000000, RUP, 4'hA, 10, URND_2, 1'b0);
    for (int k = 0; k <= 15; k++) begin
      req_valid_i = (k == 0);
      kill_i      = (k == 5);
      x_div_done  = (k >= 12 && k <= 13);
      tick();
      chk("kill_no_rsp", s_rsp_valid, 1'b0);
      if (k == 6) chk("kill_ready_next", s_req_ready, 1'b1);
    end
    kill_i = 1'b0; x_div_done = 0; req_valid_i = 1'b0;
    chk("kill_cnt", s_ops_cnt, 32'd3);

    // asynchronous reset in BUSY
    set_req(OP_DIV, 32'h40A00000, 32'h40000000, RUP, 4'd9, 20, URND_2, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      req_valid_i = (k == 0);
      tick();
    end
    req_valid_i = 1'b0;
    #3 reset_i = 1'b0;
    #2;
    chk("arst_ready", req_ready_o, 1'b0);
    chk("arst_div_start", div_start_o, 1'b0);
    chk("arst_sqrt_start", sqrt_start_o, 1'b0);
    chk("arst_valid", rsp_valid_o, 1'b0);
    chk("arst_dz", rsp_dz_o, 1'b0);
    chk("arst_tag", rsp_tag_o, 4'd0);
    chk("arst_urnd", rsp_urnd_o, 64'd0);
    chk("arst_cnt", ops_cnt_o, 32'd0);
    chk("arst_unit_rnd", unit_rnd_o, RNE);
    chk("arst_rsp_rnd", rsp_rnd_o, RNE);
    m_reset();
    @(negedge clk);
    tick();
    reset_i = 1'b1;
    tick();
    chk("arst_ready_after", s_req_ready, 1'b1);

    // counter wrap
    force dut.ops_cnt_o = 32'hFFFF_FFFF;
    #1 release dut.ops_cnt_o;
    m_cnt = 32'hFFFF_FFFF;
    rsp_ready_i = 1'b1;
    set_req(OP_SQRT, 32'h3F800000, 32'h0, RNE, 4'd5, 2, URND_2, 1'b0);
    for (int k = 0; k <= 7; k++) begin
      req_valid_i = (k == 0);
      tick();
      if (k == 2) chk("wrap_pre", s_ops_cnt, 32'hFFFF_FFFF);
    end
    req_valid_i = 1'b0;
    chk("wrap_zero", s_ops_cnt, 32'd0);

    // randomized traffic
    noise_en = 1;
    for (int c = 0; c < 600; c++) begin
      if (!req_valid_i && $urandom_range(0, 2) == 0) begin
        rand_req();
        req_valid_i = 1'b1;
      end
      rsp_ready_i = ($urandom_range(0, 9) < 7);
      kill_i      = ($urandom_range(0, 49) == 0);
      tick();
      if (s_req_ready && req_valid_i) req_valid_i = 1'b0;
    end
    kill_i = 1'b0; noise_en = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fp_divsqrt_issue.md
# fp_divsqrt_issue

Issue/sequencing stage that sits directly upstream of the iterative `fp_div` and `fp_sqrt` units and directly upstream of `fp_rnd`. It accepts one divide or square-root request at a time over a valid/ready handshake and latches the operands and rounding mode. It pulses the selected unit's start, waits for that unit's done, and captures the unrounded result plus the divide-by-zero flag. It then presents them, with the request tag, to the rounding stage over a second valid/ready handshake.

## Interface
Parameters:
- `FP_FORMAT`, default `FP32`: selects `FP_WIDTH` via `fp_width()`.
- `TAG_WIDTH`, default 4: width of the opaque request tag.

Ports:
- `clk_i` in 1: clock. The block has one clock.
- `reset_i` in 1: reset, asynchronous, active-low.
- `kill_i` in 1: synchronous abort of the in-flight operation.
- `req_valid_i` in 1 / `req_ready_o` out 1: request handshake.
- `req_op_i` in 1: 0 = DIV, 1 = SQRT.
- `req_a_i`, `req_b_i` in FP_WIDTH: operands. B is ignored for SQRT.
- `req_rnd_i` in `roundmode_e`: rounding mode for the request.
- `req_tag_i` in TAG_WIDTH: opaque tag, returned unchanged with the response.
- `div_start_o` out 1: start pulse to `fp_div`.
- `div_a_o`, `div_b_o` out FP_WIDTH: operands to `fp_div`.
- `div_done_i` in 1: done from `fp_div`.
- `div_urnd_i` in `uround_res_t`: unrounded result from `fp_div`.
- `div_dz_i` in 1: divide-by-zero flag from `fp_div`.
- `sqrt_start_o` out 1: start pulse to `fp_sqrt`.
- `sqrt_a_o` out FP_WIDTH: operand to `fp_sqrt`.
- `sqrt_done_i` in 1: done from `fp_sqrt`.
- `sqrt_urnd_i` in `uround_res_t`: unrounded result from `fp_sqrt`.
- `unit_rnd_o` out `roundmode_e`: latched rounding mode, driven to both units.
- `rsp_valid_o` out 1 / `rsp_ready_i` in 1: response handshake.
- `rsp_urnd_o` out `uround_res_t`: captured unrounded result.
- `rsp_rnd_o` out `roundmode_e`: rounding mode for `fp_rnd`.
- `rsp_dz_o` out 1: divide-by-zero flag.
- `rsp_tag_o` out TAG_WIDTH: tag of the completed request.
- `ops_cnt_o` out 32: count of completed operations.

## Operation
- FSM states: IDLE, START, BLANK, BUSY, HOLD.
- **IDLE**
  - `req_ready_o` = 1.
  - On `req_valid_i & req_ready_o`: latch op, A, B, rnd and tag, then go to START.
- **START**
  - Assert exactly one start line for one cycle: `div_start_o` if op = DIV, else `sqrt_start_o`.
  - Go to BLANK.
- **BLANK**
  - One cycle in which done is ignored. This masks a stale done level left over from the previous operation.
  - Go to BUSY.
- **BUSY**
  - Sample the selected unit's done only; the other unit's done is ignored.
  - On done: capture the selected urnd result. Capture dz = `div_dz_i` for DIV, 0 for SQRT. Go to HOLD.
- **HOLD**
  - `rsp_valid_o` = 1; the response outputs stay stable until the handshake completes.
  - On `rsp_ready_i`: increment `ops_cnt_o`.
  - In HOLD, `req_ready_o` = `rsp_ready_i`. If a request handshakes in the same cycle, go directly to START (back-to-back issue). Otherwise go to IDLE.
- **Operand and mode outputs**: `div_a_o`, `div_b_o`, `sqrt_a_o` and `unit_rnd_o` are driven from the latches and held constant from START until the FSM leaves HOLD.
- **kill_i**
  - In any state, go to IDLE next cycle and deassert `rsp_valid_o`.
  - Discard the latched request; `ops_cnt_o` is not incremented.
  - If kill arrives in START, the start pulse is still emitted that cycle. The resulting done is then ignored, because only BUSY samples done.
  - `kill_i` has priority over every other transition.
- **`ops_cnt_o`**: wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (`reset_i` = 0, asynchronous) forces:
  - FSM to IDLE;
  - `req_ready_o` = 0 while reset is asserted, then 1 once reset is released;
  - both start lines, `rsp_valid_o`, `rsp_dz_o`, `rsp_tag_o`, `rsp_urnd_o` and `ops_cnt_o` to 0;
  - `unit_rnd_o` and `rsp_rnd_o` to RNE.
- Reset asserted mid-operation discards the operation with no response.
- Latency, with the request accepted in cycle 0:
  - start is high in cycle 1;
  - BLANK is cycle 2;
  - if the unit raises done in cycle 2+N (N ≥ 1), `rsp_valid_o` is high in cycle 3+N.
- Throughput with back-to-back issue and `rsp_ready_i` held at 1: one operation per N+3 cycles.
- The block never issues a second start while an operation is in flight.

## Structure
- The op encoding typedef `divsqrt_op_e` (DIV/SQRT) and the FSM state typedef belong in `fp_pkg`.
- `uround_res_t`, `roundmode_e` and `fp_width()` are already in `fp_pkg`.
- No sub-module; `fp_div`, `fp_sqrt` and `fp_rnd` are instantiated by the parent alongside this block.

## Test plan
- **SQRT**: request SQRT A=0x40800000 (4.0), rnd RNE, tag 3; unit model gives done after 26 cycles with urnd for 2.0.
  - Required: `sqrt_start_o` is a single-cycle pulse in cycle 1; `div_start_o` stays 0.
  - Required: `rsp_valid_o` in cycle 29 with tag 3 and dz 0.
- **DIV by zero**: request DIV A=0x3F800000, B=0x00000000; model asserts `div_dz_i` = 1 with done.
  - Required: `rsp_dz_o` = 1.
  - Required: `rsp_urnd_o` equals the model's result, held while `rsp_ready_i` = 0 for 5 cycles.
- **Back-to-back**: two requests with `rsp_ready_i` = 1.
  - Required: the second start fires exactly 1 cycle after the first response handshake.
  - Required: `ops_cnt_o` = 2.
- **Stale and cross-unit done**: `sqrt_done_i` held high from the previous op into BLANK; `div_done_i` pulsed during a SQRT op.
  - Required: both are ignored; completion is taken only from a `sqrt_done_i` that is high in BUSY.
- **kill_i**: pulse `kill_i` in BUSY, then the model raises done.
  - Required: no `rsp_valid_o`; `ops_cnt_o` unchanged; `req_ready_o` = 1 the next cycle.
- **Reset and counter wrap**: assert `reset_i` = 0 mid-BUSY.
  - Required: all outputs return to their reset values immediately (asynchronously).
  - Required: `ops_cnt_o` preset via force to 0xFFFFFFFF wraps to 0 on the next completion.
